// File: rtl/pipe_flush_ctrl_pkg.sv
// pipe_flush_ctrl_pkg: shared FSM states, default parameters and mask helper for pipe_flush_ctrl
package pipe_flush_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, PEND = 2'd2} state_e;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_NUM_STAGES = 4;
  localparam int DEF_JUMP_STAGE = 2;
  localparam int DEF_FLUSH_CYCLES = 2;
  function automatic logic [31:0] low_ones(input int n);
    return (n >= 32) ? '1 : ((32'd1 << n) - 32'd1);
  endfunction
endpackage

// File: rtl/pipe_flush_ctrl_stall_prio_enc.sv
// pipe_flush_ctrl_stall_prio_enc: highest-set-bit encoder (req -> idx of top set bit, valid = any set)
module pipe_flush_ctrl_stall_prio_enc #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         valid
);
  always_comb begin
    idx = '0;
    valid = |req;
    for (int i = 0; i < N; i++) idx = req[i] ? W'(i) : idx;
  end
endmodule

// File: rtl/pipe_flush_ctrl.sv
// pipe_flush_ctrl: merges stage stalls, jump and trap redirects into hold/flush vectors and one fetch redirect
//   in : clk, rst_n (async, active low), jump_flag_in/jump_addr_in, trap_flag_in/trap_addr_in, stall_req_in
//   out: jump_flag_out/jump_addr_out (redirect), hold_out, flush_out, busy_out (state != IDLE)
module pipe_flush_ctrl
  import pipe_flush_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int JUMP_STAGE = DEF_JUMP_STAGE,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jump_flag_in,
  input  logic [ADDR_W-1:0]     jump_addr_in,
  input  logic                  trap_flag_in,
  input  logic [ADDR_W-1:0]     trap_addr_in,
  input  logic [NUM_STAGES-1:0] stall_req_in,
  output logic                  jump_flag_out,
  output logic [ADDR_W-1:0]     jump_addr_out,
  output logic [NUM_STAGES-1:0] hold_out,
  output logic [NUM_STAGES-1:0] flush_out,
  output logic                  busy_out
);
  localparam int HW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int CW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_START = CW'(FLUSH_CYCLES - 1);
  localparam logic [31:0] JM32 = low_ones(JUMP_STAGE);
  localparam logic [31:0] TM32 = low_ones(JUMP_STAGE + 1);
  localparam logic [NUM_STAGES-1:0] JMASK = JM32[NUM_STAGES-1:0];
  localparam logic [NUM_STAGES-1:0] TMASK = TM32[NUM_STAGES-1:0];
  state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [ADDR_W-1:0] pend_addr, pend_nxt, raddr;
  logic [HW-1:0] hmax;
  logic hval, stall_hi, redir;
  logic [NUM_STAGES-1:0] top, hold_base, bubble, fmask, flush_v;
  pipe_flush_ctrl_stall_prio_enc #(.N(NUM_STAGES), .W(HW)) u_enc (
    .req(stall_req_in),
    .idx(hmax),
    .valid(hval)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      pend_addr <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      pend_addr <= pend_nxt;
    end
  end
  always_comb begin
    // a stall at or beyond the jump stage blocks issuing a redirect from there
    stall_hi = |(stall_req_in & ~JMASK);
    top = NUM_STAGES'(1) << hmax;
    hold_base = hval ? (top | (top - NUM_STAGES'(1))) : '0;
    // shifting past the top stage yields 0, so no bubble when the last stage stalls
    bubble = hval ? (top << 1) : '0;
    state_nxt = state;
    cnt_nxt = cnt;
    pend_nxt = pend_addr;
    redir = 1'b0;
    raddr = '0;
    fmask = '0;
    if (state == FLUSH) begin
      fmask = JMASK;
      state_nxt = (cnt == '0) ? IDLE : FLUSH;
      cnt_nxt = (cnt == '0) ? cnt : cnt - CW'(1);
    end
    if (trap_flag_in) begin
      redir = 1'b1;
      raddr = trap_addr_in;
      fmask = TMASK;
      state_nxt = FLUSH;
      cnt_nxt = CNT_START;
    end else if (state == PEND) begin
      // the held jump stage re-presents its jump, so jump_flag_in is ignored here
      if (!stall_hi) begin
        redir = 1'b1;
        raddr = pend_addr;
        fmask = JMASK;
        state_nxt = FLUSH;
        cnt_nxt = CNT_START;
      end
    end else if (jump_flag_in) begin
      if (stall_hi) begin
        pend_nxt = jump_addr_in;
        state_nxt = PEND;
      end else begin
        redir = 1'b1;
        raddr = jump_addr_in;
        fmask = JMASK;
        state_nxt = FLUSH;
        cnt_nxt = CNT_START;
      end
    end
    flush_v = bubble | fmask;
    jump_flag_out = rst_n & redir;
    jump_addr_out = rst_n ? raddr : '0;
    flush_out = rst_n ? flush_v : '0;
    hold_out = rst_n ? (hold_base & ~flush_v) : '0;
    busy_out = rst_n & (state != IDLE);
  end
endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// tb_pipe_flush_ctrl: scoreboard bench with a cycle-level reference model of the hazard rules
module tb_pipe_flush_ctrl;
  localparam int NS = 4;
  localparam int JS = 2;
  localparam int FC = 2;
  localparam logic [3:0] JM = 4'b0011;
  localparam logic [3:0] TM = 4'b0111;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic jump_flag_in = 1'b0, trap_flag_in = 1'b0;
  logic [31:0] jump_addr_in = '0, trap_addr_in = '0;
  logic [NS-1:0] stall_req_in = '0;
  logic jump_flag_out, busy_out;
  logic [31:0] jump_addr_out;
  logic [NS-1:0] hold_out, flush_out;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [41:0] exp_q[$];
  int m_left = 0;
  bit m_pend = 0;
  logic [31:0] m_addr = '0;
  bit done = 0;

  pipe_flush_ctrl #(.ADDR_W(32), .NUM_STAGES(NS), .JUMP_STAGE(JS), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n),
    .jump_flag_in(jump_flag_in), .jump_addr_in(jump_addr_in),
    .trap_flag_in(trap_flag_in), .trap_addr_in(trap_addr_in),
    .stall_req_in(stall_req_in),
    .jump_flag_out(jump_flag_out), .jump_addr_out(jump_addr_out),
    .hold_out(hold_out), .flush_out(flush_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and push what the rules say the outputs must be this cycle.
  task automatic step(input bit r, input bit jf, input logic [31:0] ja,
                      input bit tf, input logic [31:0] ta, input logic [3:0] st);
    int h;
    bit hi, busy, jo;
    logic [31:0] ao;
    logic [3:0] hb, fl;
    @(negedge clk);
    rst_n = r; jump_flag_in = jf; jump_addr_in = ja;
    trap_flag_in = tf; trap_addr_in = ta; stall_req_in = st;
    jo = 0; ao = '0; hb = '0; fl = '0; busy = 0;
    if (!r) begin
      m_left = 0; m_pend = 0;
    end else begin
      h = -1;
      for (int k = 0; k < NS; k++) if (st[k]) h = k;
      hi = (h >= JS);
      if (h >= 0) hb = 4'((1 << (h + 1)) - 1);
      if (h >= 0 && h + 1 < NS) fl = 4'(1 << (h + 1));
      busy = (m_left > 0) || m_pend;
      if (m_left > 0) fl |= JM;
      if (tf) begin
        jo = 1; ao = ta; fl |= TM; m_left = FC; m_pend = 0;
      end else if (m_pend) begin
        if (!hi) begin jo = 1; ao = m_addr; fl |= JM; m_left = FC; m_pend = 0; end
      end else if (jf) begin
        if (hi) begin m_pend = 1; m_addr = ja; m_left = 0; end
        else begin jo = 1; ao = ja; fl |= JM; m_left = FC; end
      end else if (m_left > 0) m_left--;
      hb &= ~fl;
    end
    exp_q.push_back({busy, jo, ao, hb, fl});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, '0, 0, '0, '0);
  endtask

  initial begin
    logic [41:0] e, a;
    while (!done) begin
      @(negedge clk);
      #2;
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {busy_out, jump_flag_out, jump_addr_out, hold_out, flush_out};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL cycle%0d: got busy=%b jf=%b addr=%h hold=%b flush=%b, want busy=%b jf=%b addr=%h hold=%b flush=%b",
                   cyc, a[41], a[40], a[39:8], a[7:4], a[3:0], e[41], e[40], e[39:8], e[7:4], e[3:0]);
        end
      end
    end
  end

  initial begin
    step(0, 0, '0, 0, '0, '0);
    step(0, 0, '0, 0, '0, '0);
    idle(2);
    step(1, 1, 32'h80, 0, '0, '0);
    idle(4);
    step(1, 1, 32'h100, 0, '0, 4'b0100);
    step(1, 1, 32'h100, 0, '0, 4'b0100);
    step(1, 1, 32'h100, 0, '0, 4'b0100);
    step(1, 0, '0, 0, '0, '0);
    idle(4);
    step(1, 1, 32'h100, 0, '0, 4'b0100);
    step(1, 1, 32'h100, 0, '0, 4'b0100);
    step(1, 1, 32'h100, 1, 32'h8, 4'b0100);
    idle(5);
    step(1, 0, '0, 0, '0, 4'b0010);
    step(1, 0, '0, 0, '0, 4'b1000);
    step(1, 1, 32'h80, 0, '0, '0);
    step(1, 0, '0, 0, '0, 4'b0001);
    idle(3);
    step(1, 1, 32'h40, 0, '0, '0);
    idle(1);
    step(1, 1, 32'h60, 0, '0, '0);
    idle(4);
    step(1, 1, 32'h200, 1, 32'h10, '0);
    idle(4);
    step(1, 1, 32'h200, 0, '0, 4'b1000);
    step(0, 1, 32'h200, 0, '0, 4'b1000);
    step(0, 1, 32'h200, 0, '0, 4'b0100);
    step(1, 0, '0, 0, '0, '0);
    idle(4);
    for (int i = 0; i < 3000; i++)
      step(($urandom % 300) != 0, ($urandom % 4) == 0, {$urandom, 2'b00} >> 2,
           ($urandom % 25) == 0, {$urandom % 256, 2'b00},
           (($urandom % 3) == 0) ? 4'($urandom) : 4'b0000);
    idle(2);
    repeat (3) @(negedge clk);
    #4;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
